mii_tx_frame_sink: RTL and testbench
====================================

// Module: mii_tx_frame_sink
// PURPOSE
//  PHY-end sink for the MAC's MII transmit path: samples tx_en/tx_data and strips preamble/SFD.
//  Assembles nibbles into bytes and emits a byte stream with frame delimiters.
//  At end of frame, reports FCS (CRC-32), alignment and length status.
//  Used as the link-partner model and checker behind the ethernetlite MAC's PHY pins.
// PARAMETERS
//  MIN_FRAME  64    minimum legal frame length in bytes (DA..FCS inclusive)
//  MAX_FRAME  1518  maximum legal frame length in bytes
//  PRE_MIN    1     minimum count of 0x5 nibbles required before the SFD nibble 0xD
//  LEN_W      11    width of frame_len; saturates at 2^LEN_W-1
// PORTS
//  phy_clk      in   1      MII transmit clock; the block's only clock
//  rst          in   1      synchronous, active-high reset
//  tx_en        in   1      MAC transmit enable
//  tx_data      in   4      MAC transmit nibble; low nibble of each byte comes first
//  m_data       out  8      received byte
//  m_valid      out  1      one-cycle strobe: m_data valid; no backpressure
//  m_sof        out  1      first byte of frame; qualified by m_valid
//  m_eof        out  1      last byte of frame; qualified by m_valid
//  m_err        out  1      frame bad (CRC, odd nibble count, runt, oversize); valid with m_eof
//  frame_len    out  LEN_W  byte count incl. FCS; valid with m_eof
//  frm_ok_cnt   out  16     good frames; wraps modulo 2^16
//  frm_err_cnt  out  16     bad or dropped frames; wraps modulo 2^16
// BEHAVIOUR
//  Reset: state=IDLE; every output register is 0; CRC=0xFFFFFFFF.
//  FSM states, all transitions on phy_clk:
//   IDLE: tx_en=1 & nibble 0x5 -> PRE. tx_en=1 & nibble other -> DROP.
//   PRE: 0x5 increments the preamble count. 0xD with count>=PRE_MIN -> DATA.
//        Any other nibble -> DROP. tx_en=0 -> IDLE and frm_err_cnt++.
//   DATA: even nibble is stored as the low half. Odd nibble completes a byte.
//         tx_en=0 -> IDLE and close the frame.
//   DROP: no output. On tx_en=0 -> IDLE and frm_err_cnt++.
//  One-byte holding register supplies the eof lookahead:
//   Byte k completes at edge t; byte k-1 (if any) is emitted with m_valid=1 at t+1.
//   tx_en sampled 0 at edge te: the held byte is emitted at te+1 with m_eof=1.
//   m_err and frame_len are valid in that same te+1 cycle.
//   m_sof=1 on the first emitted byte. A 1-byte frame gets m_sof=m_eof=1 on one beat.
//  CRC: IEEE 802.3 reflected CRC-32 over all bytes incl. FCS. Good iff residue==0xC704DD7B.
//  m_err=1 if any of: bad residue; odd nibble count at close; len<MIN_FRAME; len>MAX_FRAME.
//   On an odd-nibble close, the stray nibble is discarded.
//  Counters: frm_ok_cnt++ if m_err=0, else frm_err_cnt++; one update per closed frame.
//  Zero-byte frame (SFD then tx_en=0): nothing emitted; frm_err_cnt++.
//  Oversize frame: bytes are still emitted; frame_len saturates.
//  frame_len holds its value until the next eof. m_data holds its value between strobes.
//  m_sof/m_eof/m_err are 0 whenever m_valid=0.
//  Reset mid-frame: the held byte is lost; no eof is emitted; counters clear.
//   If tx_en is still 1 after reset, the block stays in DROP until tx_en=0.
//  tx_en may return high the cycle after falling (zero IPG). Next frame starts from IDLE on that edge.
// TESTING
//  Good frame: 15x0x5+0xD, 60B payload + valid FCS -> 64 strobes; sof on #1; eof on #64.
//   At eof: m_err=0, frame_len=64, frm_ok_cnt=1.
//  Same frame with byte 10 bit 0 flipped -> m_err=1 at eof; frm_err_cnt=1; 64 strobes still emitted.
//  Good 64B frame plus one extra nibble before tx_en=0 -> 64 strobes; m_err=1 (alignment).
//  Runt: 20B incl. valid FCS -> frame_len=20, m_err=1. 1600B frame -> m_err=1, frame_len=1600.
//  Preamble 0x5,0x5,0x7 then 64B -> no m_valid; frm_err_cnt increments by 1.
//  rst=1 for 1 cycle at byte 30 of a frame -> no eof, counters=0.
//   Next good back-to-back frame (zero IPG) -> frm_ok_cnt=1.

Source files
------------

// File: rtl/mii_tx_frame_sink.sv
// PHY-end MII transmit sink: strips preamble/SFD, assembles nibbles into a byte
// stream with sof/eof markers, and reports CRC-32, alignment and length status per frame.
module mii_tx_frame_sink #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int PRE_MIN   = 1,
  parameter int LEN_W     = 11
) (
  input  logic             phy_clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [3:0]       tx_data,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic             m_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [15:0]      frm_ok_cnt,
  output logic [15:0]      frm_err_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [31:0]      CRC_POLY = 32'hEDB88320;
  localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0]      CRC_GOOD = 32'hC704DD7B;
  localparam logic [LEN_W-1:0] LEN_SAT  = '1;
  localparam logic [7:0]       PRE_SAT  = '1;

  state_t           state, state_nxt;
  logic             en_q;
  logic [7:0]       pre_cnt;
  logic [3:0]       low_nib;
  logic             nib_odd;
  logic [7:0]       hold;
  logic             hold_vld;
  logic             sof_pend;
  logic [LEN_W-1:0] byte_cnt;
  logic [31:0]      crc;

  logic             pre_start, sfd_seen, frame_close, abort, close_bad;
  logic [7:0]       byte_new;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] data);
    logic [31:0] c;
    c = c_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  // The reflected register holds the residue LSB-first; compare it in normal bit order.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always_ff @(posedge phy_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (tx_en) state_nxt = (tx_data == 4'h5 && !en_q) ? PRE : DROP;
      PRE: begin
        if (!tx_en)                                        state_nxt = IDLE;
        else if (tx_data == 4'hD && pre_cnt >= 8'(PRE_MIN)) state_nxt = DATA;
        else if (tx_data != 4'h5)                          state_nxt = DROP;
      end
      DATA:    if (!tx_en) state_nxt = IDLE;
      DROP:    if (!tx_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pre_start   = (state == IDLE) && (state_nxt == PRE);
    sfd_seen    = (state == PRE) && (state_nxt == DATA);
    frame_close = (state == DATA) && !tx_en;
    abort       = ((state == PRE) || (state == DROP)) && !tx_en;
    byte_new    = {tx_data, low_nib};
    close_bad   = (bit_rev32(crc) != CRC_GOOD) || nib_odd ||
                  (byte_cnt < LEN_W'(MIN_FRAME)) || (byte_cnt > LEN_W'(MAX_FRAME));
  end

  // en_q resets high: a frame already in flight when reset releases is dropped, not re-synced.
  always_ff @(posedge phy_clk) begin
    if (rst) begin
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      m_err       <= 1'b0;
      frame_len   <= '0;
      frm_ok_cnt  <= '0;
      frm_err_cnt <= '0;
      en_q        <= 1'b1;
      pre_cnt     <= '0;
      low_nib     <= '0;
      nib_odd     <= 1'b0;
      hold        <= '0;
      hold_vld    <= 1'b0;
      sof_pend    <= 1'b0;
      byte_cnt    <= '0;
      crc         <= CRC_INIT;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      en_q    <= tx_en;
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
      m_err   <= 1'b0;

      if (pre_start)
        pre_cnt <= 8'd1;
      else if (state == PRE && tx_en && tx_data == 4'h5 && pre_cnt != PRE_SAT)
        pre_cnt <= pre_cnt + 8'd1;

      if (sfd_seen) begin
        nib_odd  <= 1'b0;
        hold_vld <= 1'b0;
        sof_pend <= 1'b1;
        byte_cnt <= '0;
        crc      <= CRC_INIT;
      end

      if (state == DATA && tx_en) begin
        if (!nib_odd) begin
          low_nib <= tx_data;
          nib_odd <= 1'b1;
        end else begin
          nib_odd  <= 1'b0;
          hold     <= byte_new;
          hold_vld <= 1'b1;
          crc      <= crc_byte(crc, byte_new);
          if (byte_cnt != LEN_SAT) byte_cnt <= byte_cnt + 1'b1;
          if (hold_vld) begin
            m_valid  <= 1'b1;
            m_data   <= hold;
            m_sof    <= sof_pend;
            sof_pend <= 1'b0;
          end
        end
      end

      if (frame_close) begin
        nib_odd  <= 1'b0;
        hold_vld <= 1'b0;
        sof_pend <= 1'b0;
        crc      <= CRC_INIT;
        if (hold_vld) begin
          m_valid   <= 1'b1;
          m_data    <= hold;
          m_sof     <= sof_pend;
          m_eof     <= 1'b1;
          m_err     <= close_bad;
          frame_len <= byte_cnt;
          if (close_bad) frm_err_cnt <= frm_err_cnt + 16'd1;
          else           frm_ok_cnt  <= frm_ok_cnt + 16'd1;
        end else begin
          frm_err_cnt <= frm_err_cnt + 16'd1;
        end
      end

      if (abort) frm_err_cnt <= frm_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mii_tx_frame_sink.sv
// Directed bench for mii_tx_frame_sink: drives nibble streams, builds FCS with its
// own CRC-32 model, and checks strobe counts, delimiters, status and counters.
module tb_mii_tx_frame_sink;
  localparam int LEN_W = 11;

  logic             phy_clk = 1'b0;
  logic             rst;
  logic             tx_en;
  logic [3:0]       tx_data;
  logic [7:0]       m_data;
  logic             m_valid, m_sof, m_eof, m_err;
  logic [LEN_W-1:0] frame_len;
  logic [15:0]      frm_ok_cnt, frm_err_cnt;

  always #5 phy_clk = ~phy_clk;

  mii_tx_frame_sink #(.MIN_FRAME(64), .MAX_FRAME(1518), .PRE_MIN(1), .LEN_W(LEN_W)) dut (
    .phy_clk     (phy_clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .m_err       (m_err),
    .frame_len   (frame_len),
    .frm_ok_cnt  (frm_ok_cnt),
    .frm_err_cnt (frm_err_cnt)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] fb [0:1599];
  logic [4:0] stream [$];

  int strobes, sof_cnt, sof_at, eof_cnt, eof_at, eof_err, eof_len, data_mis, qual_bad, idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge phy_clk) begin
    if (m_valid === 1'b1) begin
      strobes++;
      if (m_sof) begin
        sof_cnt++;
        sof_at = strobes;
        idx    = 0;
      end
      if (idx < 1600 && m_data !== fb[idx]) data_mis++;
      idx++;
      if (m_eof) begin
        eof_cnt++;
        eof_at  = strobes;
        eof_err = int'(m_err);
        eof_len = int'(frame_len);
      end
    end else if ((m_sof | m_eof | m_err) === 1'b1) begin
      qual_bad++;
    end
  end

  task automatic clear_stats();
    strobes = 0; sof_cnt = 0; sof_at = 0; eof_cnt = 0; eof_at = 0;
    eof_err = -1; eof_len = -1; data_mis = 0; qual_bad = 0; idx = 0;
  endtask

  // Reference reflected CRC-32 (poly 0xEDB88320), returns the FCS value (inverted).
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int len, input bit flip);
    int          n;
    logic [31:0] fcs;
    n = (len >= 4) ? len - 4 : len;
    for (int i = 0; i < n; i++) fb[i] = 8'(i * 37 + 11);
    if (len >= 4) begin
      fcs = fcs_of(n);
      for (int k = 0; k < 4; k++) fb[n+k] = fcs[8*k +: 8];
    end
    if (flip) fb[10] = fb[10] ^ 8'h01;
  endtask

  task automatic push_pre(input int n);
    for (int i = 0; i < n; i++) stream.push_back(5'h15);
    stream.push_back(5'h1D);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      stream.push_back({1'b1, fb[i][3:0]});
      stream.push_back({1'b1, fb[i][7:4]});
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) stream.push_back(5'h00);
  endtask

  task automatic drive1(input logic [4:0] e, input logic r);
    @(posedge phy_clk);
    #1;
    tx_en   = e[4];
    tx_data = e[3:0];
    rst     = r;
  endtask

  task automatic play(input int rst_at);
    foreach (stream[i]) drive1(stream[i], i == rst_at);
    stream.delete();
  endtask

  initial begin
    int rst_idx;
    rst = 1'b1; tx_en = 1'b0; tx_data = 4'h0;
    clear_stats();
    repeat (2) @(posedge phy_clk);
    #1 rst = 1'b0;
    @(negedge phy_clk);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_len", frame_len, 0);
    check("rst_ok", frm_ok_cnt, 0);
    check("rst_err", frm_err_cnt, 0);

    // Good 64-byte frame with 15-nibble preamble
    build(64, 0); clear_stats();
    push_pre(15); push_range(0, 64); push_idle(4); play(-1);
    check("good_strobes", strobes, 64);
    check("good_sof_cnt", sof_cnt, 1);
    check("good_sof_at", sof_at, 1);
    check("good_eof_at", eof_at, 64);
    check("good_err", eof_err, 0);
    check("good_len", eof_len, 64);
    check("good_ok", frm_ok_cnt, 1);
    check("good_errcnt", frm_err_cnt, 0);
    check("good_data", data_mis, 0);

    // Byte 10 bit 0 flipped after FCS computed
    build(64, 1); clear_stats();
    push_pre(15); push_range(0, 64); push_idle(4); play(-1);
    check("crc_strobes", strobes, 64);
    check("crc_err", eof_err, 1);
    check("crc_errcnt", frm_err_cnt, 1);
    check("crc_ok", frm_ok_cnt, 1);

    // Stray trailing nibble
    build(64, 0); clear_stats();
    push_pre(15); push_range(0, 64); stream.push_back(5'h13); push_idle(4); play(-1);
    check("align_strobes", strobes, 64);
    check("align_err", eof_err, 1);
    check("align_len", eof_len, 64);
    check("align_errcnt", frm_err_cnt, 2);

    // Runt with valid FCS
    build(20, 0); clear_stats();
    push_pre(15); push_range(0, 20); push_idle(4); play(-1);
    check("runt_strobes", strobes, 20);
    check("runt_len", eof_len, 20);
    check("runt_err", eof_err, 1);
    check("runt_errcnt", frm_err_cnt, 3);

    // Oversize with valid FCS
    build(1600, 0); clear_stats();
    push_pre(15); push_range(0, 1600); push_idle(4); play(-1);
    check("over_strobes", strobes, 1600);
    check("over_len", eof_len, 1600);
    check("over_err", eof_err, 1);
    check("over_data", data_mis, 0);
    check("over_errcnt", frm_err_cnt, 4);

    // Bad preamble 5,5,7
    build(64, 0); clear_stats();
    stream.push_back(5'h15); stream.push_back(5'h15); stream.push_back(5'h17);
    push_range(0, 64); push_idle(4); play(-1);
    check("badpre_strobes", strobes, 0);
    check("badpre_errcnt", frm_err_cnt, 5);

    // Zero-byte frame: SFD then tx_en low; frame_len keeps its last value
    clear_stats();
    push_pre(15); push_idle(4); play(-1);
    check("zero_strobes", strobes, 0);
    check("zero_errcnt", frm_err_cnt, 6);
    check("zero_len_hold", frame_len, 1600);

    // One-byte frame: sof and eof on the same beat
    build(1, 0); clear_stats();
    push_pre(3); push_range(0, 1); push_idle(4); play(-1);
    check("one_strobes", strobes, 1);
    check("one_sof_at", sof_at, 1);
    check("one_eof_at", eof_at, 1);
    check("one_len", eof_len, 1);
    check("one_err", eof_err, 1);
    check("one_errcnt", frm_err_cnt, 7);
    check("qual_zero", qual_bad, 0);

    // Reset pulse during byte 30, then tail of that frame and a zero-IPG good frame
    build(64, 0); clear_stats();
    push_pre(15); push_range(0, 30); stream.push_back({1'b1, fb[30][3:0]});
    rst_idx = stream.size() - 1;
    play(rst_idx);
    drive1({1'b1, fb[30][7:4]}, 1'b0);
    @(negedge phy_clk);
    check("mid_rst_ok", frm_ok_cnt, 0);
    check("mid_rst_err", frm_err_cnt, 0);
    check("mid_rst_eof", eof_cnt, 0);
    check("mid_rst_valid", m_valid, 0);
    clear_stats();
    push_range(31, 64); push_idle(1); push_pre(15); push_range(0, 64); push_idle(4); play(-1);
    check("b2b_eof_cnt", eof_cnt, 1);
    check("b2b_strobes", strobes, 64);
    check("b2b_sof_at", sof_at, 1);
    check("b2b_err", eof_err, 0);
    check("b2b_len", eof_len, 64);
    check("b2b_ok", frm_ok_cnt, 1);
    check("b2b_errcnt", frm_err_cnt, 1);
    check("b2b_data", data_mis, 0);
    check("b2b_qual", qual_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
